// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, control
// constants, aluop codes and helpers that classify memory operations.
package mem_stage_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;
  localparam int AluOpBus   = 8;
  localparam int MemBus     = 8;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic NoStop      = 1'b0;

  // Memory aluop codes; every other code is a non-memory op.
  localparam logic [AluOpBus-1:0] EX_NOP = 8'h00;
  localparam logic [AluOpBus-1:0] EX_LB  = 8'hE0;
  localparam logic [AluOpBus-1:0] EX_LH  = 8'hE1;
  localparam logic [AluOpBus-1:0] EX_LW  = 8'hE2;
  localparam logic [AluOpBus-1:0] EX_LBU = 8'hE4;
  localparam logic [AluOpBus-1:0] EX_LHU = 8'hE5;
  localparam logic [AluOpBus-1:0] EX_SB  = 8'hE8;
  localparam logic [AluOpBus-1:0] EX_SH  = 8'hE9;
  localparam logic [AluOpBus-1:0] EX_SW  = 8'hEA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_load(input logic [AluOpBus-1:0] op);
    return (op == EX_LB) || (op == EX_LH) || (op == EX_LW) ||
           (op == EX_LBU) || (op == EX_LHU);
  endfunction

  function automatic logic op_is_store(input logic [AluOpBus-1:0] op);
    return (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
  endfunction

  // Number of bytes moved by a memory op (0 for non-memory ops).
  function automatic logic [2:0] op_len(input logic [AluOpBus-1:0] op);
    logic [2:0] len;
    case (op)
      EX_LB, EX_LBU, EX_SB: len = 3'd1;
      EX_LH, EX_LHU, EX_SH: len = 3'd2;
      EX_LW, EX_SW:         len = 3'd4;
      default:              len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-serial memory-controller port.
// Handshake: the master raises req with wr/addr/wdata and holds all of them
// stable until the slave pulses ready for exactly one cycle; ready marks the
// byte as complete and, for reads, qualifies rdata in that same cycle.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  import mem_stage_pkg::*;

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [MemBus-1:0] wdata;
  logic              ready;
  logic [MemBus-1:0] rdata;

  modport master (output req, wr, addr, wdata, input ready, rdata);
  modport slave  (input req, wr, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of the assembled load buffer according to the load op.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop,
  input  logic [RegBus-1:0]   data_buf,
  output logic [RegBus-1:0]   data
);

  // Select the lanes the op loaded and widen them to a full register.
  always_comb begin
    data = '0;
    case (aluop)
      EX_LB:   data = {{24{data_buf[7]}}, data_buf[7:0]};
      EX_LBU:  data = {24'h000000, data_buf[7:0]};
      EX_LH:   data = {{16{data_buf[15]}}, data_buf[15:0]};
      EX_LHU:  data = {16'h0000, data_buf[15:0]};
      EX_LW:   data = data_buf;
      EX_NOP:  data = '0;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: non-memory ops pass straight through; loads and
// stores are run as byte-serial transactions on the memory-controller port
// while a stall request holds the rest of the pipeline.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ALUOP_W = AluOpBus,
  parameter int ADDR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [RegAddrBus-1:0] mem_wd_i,
  input  logic                  mem_wreg_i,
  input  logic [RegBus-1:0]     mem_wdata_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [ALUOP_W-1:0]    mem_aluop_i,
  input  logic                  wb_stall_i,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  stallreq_o,
  mem_stage_if.master           mc,
  output state_t                dbg_state
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        byte_cnt;
  logic [1:0]        nxt_cnt;
  logic [RegBus-1:0] data_buf;
  logic [RegBus-1:0] ext_data;
  logic              req_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [MemBus-1:0] wdata_q;

  logic       is_ld;
  logic       is_st;
  logic       is_mem;
  logic [2:0] len;
  logic       last_byte;

  assign is_ld     = op_is_load(mem_aluop_i);
  assign is_st     = op_is_store(mem_aluop_i);
  assign is_mem    = is_ld | is_st;
  assign len       = op_len(mem_aluop_i);
  assign nxt_cnt   = byte_cnt + 2'd1;
  assign last_byte = ({1'b0, byte_cnt} == (len - 3'd1));

  assign mc.req    = req_q;
  assign mc.wr     = wr_q;
  assign mc.addr   = addr_q;
  assign mc.wdata  = wdata_q;
  assign dbg_state = state;

  mem_stage_load_ext u_load_ext (
    .aluop    (mem_aluop_i),
    .data_buf (data_buf),
    .data     (ext_data)
  );

  // State register; rdy low freezes the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  // Next state: start on a memory op, finish on the last byte's ready,
  // leave DONE only once the MEM/WB register can accept the result.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (is_mem) state_nxt = ST_BUSY;
      ST_BUSY: if (mc.ready && last_byte) state_nxt = ST_DONE;
      ST_DONE: if (!wb_stall_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte counter, load buffer and registered memory-port fields. The request
  // is held through all bytes of an op and dropped on the last ready, so the
  // DONE and IDLE cycles always separate two ops with req low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      data_buf <= '0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          if (is_mem) begin
            byte_cnt <= '0;
            data_buf <= '0;
            req_q    <= 1'b1;
            wr_q     <= is_st ? WriteEnable : ~WriteEnable;
            addr_q   <= mem_addr_i;
            wdata_q  <= mem_wdata_i[7:0];
          end
        end
        ST_BUSY: begin
          if (mc.ready) begin
            if (is_ld) data_buf[{byte_cnt, 3'b000} +: 8] <= mc.rdata;
            if (last_byte) begin
              req_q <= 1'b0;
            end else begin
              byte_cnt <= nxt_cnt;
              addr_q   <= mem_addr_i + ADDR_W'(nxt_cnt);
              wdata_q  <= mem_wdata_i[{nxt_cnt, 3'b000} +: 8];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs: pass-through in IDLE for non-memory ops, stall while an access
  // is pending, deliver the extended load result in DONE; all zero in reset.
  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stallreq_o = NoStop;
    if (rst != RstEnable) begin
      case (state)
        ST_IDLE: begin
          if (is_mem) begin
            stallreq_o = ~NoStop;
          end else begin
            wd_o    = mem_wd_i;
            wreg_o  = mem_wreg_i;
            wdata_o = mem_wdata_i;
          end
        end
        ST_BUSY: stallreq_o = ~NoStop;
        ST_DONE: begin
          wd_o    = mem_wd_i;
          wreg_o  = is_ld ? mem_wreg_i : 1'b0;
          wdata_o = is_ld ? ext_data : '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, reset/freeze sequences and
// randomized ops checked against a byte-array memory model and an access
// scoreboard.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [7:0] OP_ADD = 8'h21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_aluop;
  logic        wb_stall;
  logic [4:0]  wd;
  logic        wreg;
  logic [31:0] wdata;
  logic        stallreq;
  state_t      dbg_state;

  mem_stage_if #(.ADDR_W(32)) mc ();

  mem_stage #(.ALUOP_W(8), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .mem_wd_i    (mem_wd),
    .mem_wreg_i  (mem_wreg),
    .mem_wdata_i (mem_wdata),
    .mem_addr_i  (mem_addr),
    .mem_aluop_i (mem_aluop),
    .wb_stall_i  (wb_stall),
    .wd_o        (wd),
    .wreg_o      (wreg),
    .wdata_o     (wdata),
    .stallreq_o  (stallreq),
    .mc          (mc),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passed = 0;
  logic [40:0] exp_q[$];
  logic [40:0] act_q[$];
  logic [7:0]  mem [logic [31:0]];
  int mem_lat = 1;
  int lat_cnt = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdv;
    logic [4:0]  rd;
    logic        we;
    int          lat;
    int          hold;
    int          gap_at;
    int          gap_len;
    logic [31:0] pre;
    logic [31:0] exp_data;
    logic        exp_wreg;
    int          exp_stall;
  } vec_t;

  vec_t vecs[13];
  logic [7:0] rand_ops[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic int ref_len(input logic [7:0] op);
    if (op == EX_LB || op == EX_LBU || op == EX_SB) return 1;
    if (op == EX_LH || op == EX_LHU || op == EX_SH) return 2;
    if (op == EX_LW || op == EX_SW) return 4;
    return 0;
  endfunction

  function automatic bit ref_store(input logic [7:0] op);
    return (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
  endfunction

  // Little-endian value of the bytes at a.., then two's-complement for signed loads.
  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] a);
    longint v;
    v = 0;
    for (int i = 0; i < ref_len(op); i++)
      v += longint'(mem_rd(a + 32'(i))) * (longint'(1) << (8 * i));
    if (op == EX_LB && v >= 128) v -= 256;
    if (op == EX_LH && v >= 32768) v -= 65536;
    return v[31:0];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] bytes, input int n);
    for (int i = 0; i < n; i++) mem[a + 32'(i)] = bytes[8*i +: 8];
  endtask

  // ---------------- memory controller model ----------------
  // Answers each requested byte after mem_lat cycles with req high; frozen by rdy.
  always @(negedge clk) begin
    if (rst) begin
      mc.ready = 1'b0;
      lat_cnt  = 0;
    end else if (!rdy) begin
      mc.ready = 1'b0;
    end else if (mc.req) begin
      lat_cnt++;
      if (lat_cnt >= mem_lat) begin
        lat_cnt  = 0;
        mc.ready = 1'b1;
        act_q.push_back({mc.wr, mc.addr, mc.wr ? mc.wdata : 8'h00});
        mc.rdata = mc.wr ? 8'($urandom) : mem_rd(mc.addr);
      end else begin
        mc.ready = 1'b0;
        mc.rdata = 8'($urandom);
      end
    end else begin
      mc.ready = 1'b0;
      lat_cnt  = 0;
      mc.rdata = 8'($urandom);
    end
  end

  // ---------------- driver ----------------
  task automatic drive_nop();
    mem_aluop = EX_NOP; mem_addr = '0; mem_wdata = '0;
    mem_wd = '0; mem_wreg = 1'b0; wb_stall = 1'b0;
  endtask

  // Runs one op starting at posedge+1; returns at posedge+1 after the stage
  // has released it, with NOP on the inputs.
  task automatic run_op(input int idx, input vec_t v);
    int  len;
    int  stall_cnt;
    int  cyc;
    bit  done;
    bit  st;
    len = ref_len(v.op);
    st  = ref_store(v.op);
    if (len > 0 && !st) preload(v.addr, v.pre, len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({st, v.addr + 32'(i), st ? v.wdv[8*i +: 8] : 8'h00});
    mem_lat   = v.lat;
    mem_aluop = v.op;
    mem_addr  = v.addr;
    mem_wdata = v.wdv;
    mem_wd    = v.rd;
    mem_wreg  = v.we;
    wb_stall  = (v.hold > 0);
    stall_cnt = 0;
    cyc       = 0;
    done      = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (stallreq) stall_cnt++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
        if (v.gap_len > 0 && cyc == v.gap_at) rdy = 1'b0;
        if (v.gap_len > 0 && cyc == v.gap_at + v.gap_len) rdy = 1'b1;
        if (cyc > 300) begin
          checks++;
          $display("FAIL op%0d stall_timeout: stallreq still 1 after %0d cycles", idx, cyc);
          done = 1'b1;
        end
      end
    end
    rdy = 1'b1;
    check($sformatf("op%0d stall_cycles", idx), 64'(stall_cnt), 64'(v.exp_stall));
    check($sformatf("op%0d wd", idx), 64'(wd), 64'(v.rd));
    check($sformatf("op%0d wreg", idx), 64'(wreg), 64'(v.exp_wreg));
    check($sformatf("op%0d wdata", idx), 64'(wdata), 64'(v.exp_data));
    check($sformatf("op%0d req_low", idx), 64'(mc.req), 64'(0));
    for (int h = 1; h <= v.hold; h++) begin
      @(posedge clk); #1;
      if (h == v.hold) wb_stall = 1'b0;
      @(negedge clk);
      check($sformatf("op%0d hold%0d", idx, h),
            {23'd0, dbg_state, mc.req, stallreq, wreg, wdata},
            {23'd0, ST_DONE, 1'b0, 1'b0, v.exp_wreg, v.exp_data});
    end
    @(posedge clk); #1;
    drive_nop();
    check($sformatf("op%0d back_to_idle", idx), 64'(dbg_state), 64'(ST_IDLE));
    check($sformatf("op%0d access_count", idx), 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("op%0d access%0d", idx, i), 64'(act_q[i]), 64'(exp_q[i]));
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_outputs"}, {25'd0, wd, wreg, wdata, stallreq}, 64'd0);
    check({name, "_mc"}, {22'd0, mc.req, mc.wr, mc.addr, mc.wdata}, 64'd0);
    check({name, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t rv;
    int   rlen;
    drive_nop();

    //          op      addr           wdv            rd   we  lat hold gat glen pre            exp_data      wreg stall
    vecs[0]  = '{OP_ADD, 32'h0000_0000, 32'h1234_5678, 5'd5,  1'b1, 1, 0, 0, 0, 32'h0,         32'h1234_5678, 1'b1, 0};
    vecs[1]  = '{EX_LW,  32'h0000_1000, 32'h0,         5'd7,  1'b1, 2, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 1'b1, 9};
    vecs[2]  = '{EX_LB,  32'h0000_2003, 32'h0,         5'd8,  1'b1, 1, 0, 0, 0, 32'h80,        32'hFFFF_FF80, 1'b1, 2};
    vecs[3]  = '{EX_LBU, 32'h0000_2003, 32'h0,         5'd9,  1'b1, 1, 0, 0, 0, 32'h80,        32'h0000_0080, 1'b1, 2};
    vecs[4]  = '{EX_LH,  32'h0000_2010, 32'h0,         5'd10, 1'b1, 1, 0, 0, 0, 32'h7FFF,      32'h0000_7FFF, 1'b1, 3};
    vecs[5]  = '{EX_SH,  32'h0000_3001, 32'hAABB_CCDD, 5'd11, 1'b1, 1, 0, 0, 0, 32'h0,         32'h0,         1'b0, 3};
    vecs[6]  = '{EX_LW,  32'h0000_1000, 32'h0,         5'd12, 1'b1, 3, 3, 2, 2, 32'h1234_5678, 32'h1234_5678, 1'b1, 15};
    vecs[7]  = '{EX_LH,  32'h0000_4000, 32'h0,         5'd13, 1'b1, 2, 1, 0, 0, 32'h8001,      32'hFFFF_8001, 1'b1, 5};
    vecs[8]  = '{EX_LHU, 32'h0000_4000, 32'h0,         5'd14, 1'b1, 1, 0, 0, 0, 32'h8001,      32'h0000_8001, 1'b1, 3};
    vecs[9]  = '{EX_SW,  32'h0000_5002, 32'hCAFE_F00D, 5'd15, 1'b1, 2, 2, 3, 1, 32'h0,         32'h0,         1'b0, 10};
    vecs[10] = '{EX_LW,  32'hFFFF_FFFE, 32'h0,         5'd16, 1'b1, 1, 0, 0, 0, 32'h4433_2211, 32'h4433_2211, 1'b1, 5};
    vecs[11] = '{EX_SB,  32'h0000_6000, 32'h0000_00A5, 5'd17, 1'b1, 1, 0, 0, 0, 32'h0,         32'h0,         1'b0, 2};
    vecs[12] = '{EX_LB,  32'h0000_2003, 32'h0,         5'd18, 1'b0, 1, 0, 0, 0, 32'h80,        32'hFFFF_FF80, 1'b0, 2};

    rand_ops = '{OP_ADD, EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU, EX_SB, EX_SH, EX_SW};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 13; i++) run_op(i, vecs[i]);

    // reset in the middle of a load, then the same load restarts at byte 0
    preload(32'h0000_1000, 32'h1234_5678, 4);
    mem_lat = 2; mem_aluop = EX_LW; mem_addr = 32'h0000_1000; mem_wd = 5'd3; mem_wreg = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    act_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(100, vecs[1]);

    // randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      rv.op   = rand_ops[$urandom_range(0, 8)];
      rv.addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                            : (32'h0000_0100 + 32'($urandom_range(0, 255)));
      rv.wdv  = $urandom;
      rv.rd   = 5'($urandom);
      rv.we   = 1'($urandom);
      rv.lat  = $urandom_range(1, 3);
      rv.pre  = $urandom;
      rlen    = ref_len(rv.op);
      rv.hold = (rlen > 0) ? $urandom_range(0, 2) : 0;
      rv.gap_len = 0;
      rv.gap_at  = 0;
      if (rlen > 0 && $urandom_range(0, 1) == 1) begin
        rv.gap_len = $urandom_range(1, 2);
        rv.gap_at  = $urandom_range(1, rlen * rv.lat);
      end
      if (rlen == 0) begin
        rv.exp_data  = rv.wdv;
        rv.exp_wreg  = rv.we;
        rv.exp_stall = 0;
      end else begin
        rv.exp_stall = 1 + rlen * rv.lat + rv.gap_len;
        if (ref_store(rv.op)) begin
          rv.exp_data = 32'h0;
          rv.exp_wreg = 1'b0;
        end else begin
          preload(rv.addr, rv.pre, rlen);
          rv.exp_data = ref_load(rv.op, rv.addr);
          rv.exp_wreg = rv.we;
        end
      end
      run_op(200 + n, rv);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the 5-stage RISC-V pipeline. It sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Non-memory ops pass through combinationally.
- Loads and stores run as byte-serial transactions on the 8-bit memory-controller port.
- While a transaction is in flight, the stage raises a stall request to the central stall controller.

Parameters:
ALUOP_W, 8, width of the aluop bus; must equal the shared package AluOpBus width
ADDR_W, 32, memory address width

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
rdy  in  1  global ready; when low, all state is frozen
mem_wd_i  in  5  destination register address
mem_wreg_i  in  1  register write enable
mem_wdata_i  in  32  ALU result, or store data for stores
mem_addr_i  in  ADDR_W  effective load/store address
mem_aluop_i  in  ALUOP_W  operation code
wb_stall_i  in  1  stall[5] level; MEM/WB register is holding
wd_o  out  5  destination register address to MEM/WB
wreg_o  out  1  register write enable to MEM/WB
wdata_o  out  32  writeback data to MEM/WB
stallreq_o  out  1  stall request to the stall controller
mc_req_o  out  1  byte request to the memory controller
mc_wr_o  out  1  1 = write, 0 = read
mc_addr_o  out  ADDR_W  byte address
mc_wdata_o  out  8  write byte
mc_ready_i  in  1  one-cycle pulse: current byte completed
mc_rdata_i  in  8  read byte; valid when mc_ready_i is high

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; byte_cnt=0; data_buf=0.
  - All outputs are 0: mc_req_o, mc_wr_o, mc_addr_o, mc_wdata_o, stallreq_o, wd_o, wreg_o, wdata_o.
- rdy=0: no register changes. Outputs hold their current values.
- Operation classes:
  - LB/LH/LW/LBU/LHU: load; length 1/2/4/1/2 bytes.
  - SB/SH/SW: store; length 1/2/4 bytes.
  - Anything else: non-memory.
- Byte order is little-endian. Misaligned addresses are legal; each byte uses address base+byte_cnt (32-bit wrap).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Non-memory op: outputs = inputs combinationally; stallreq_o=0.
  - Memory op:
    - stallreq_o=1 combinationally.
    - Next edge: go to BUSY; byte_cnt=0.
    - Registered mc_req_o=1, mc_addr_o=base, mc_wr_o=is_store, mc_wdata_o=wdata[7:0].
- BUSY:
  - mc_req_o and the address/data fields stay stable until mc_ready_i.
  - stallreq_o=1.
  - On mc_ready_i:
    - Load: capture mc_rdata_i into data_buf byte lane byte_cnt.
    - byte_cnt++; the address and write byte advance to the next lane.
    - If byte_cnt == len-1: drop mc_req_o and go to DONE.
  - mc_req_o is deasserted for at least one cycle between instructions. It is not deasserted between bytes of the same instruction.
- DONE:
  - stallreq_o=0.
  - wd_o = mem_wd_i.
  - wreg_o = mem_wreg_i for loads; 0 for stores.
  - wdata_o:
    - LB/LH: sign-extend data_buf.
    - LBU/LHU: zero-extend data_buf.
    - LW: full word.
    - Stores: 0.
  - Stay in DONE while wb_stall_i=1; no re-issue of the access.
  - Go to IDLE on the first edge with wb_stall_i=0.
- Latency: a load/store of N bytes with ready latency L per byte deasserts stallreq after 1+N*L cycles.
- mc_ready_i seen outside BUSY: ignored.
- Reset mid-transaction: the transaction is abandoned. Partial stores may have landed in memory; this is acceptable.
- Inputs are required stable while stallreq_o=1; the EX/MEM register guarantees this.

Decomposition:
- Shared defines header holds:
  - aluop codes EX_LB…EX_SW, EX_NOP
  - RegAddrBus, RegBus, AluOpBus, MemBus widths
  - RstEnable, WriteEnable, NoStop
- Optional sub-module mem_load_ext (combinational): sign/zero extension of data_buf by aluop.

Test Plan:
- Reset with rst=1 mid-BUSY -> all outputs 0, FSM IDLE; the next LW restarts at byte 0.
- Non-memory op, wdata=0x12345678, wd=5, wreg=1 -> same-cycle wd_o=5, wdata_o=0x12345678, stallreq_o=0, mc_req_o never set.
- LW addr 0x1000, memory bytes 78 56 34 12, ready latency 2 -> 4 reads at 0x1000..0x1003; wdata_o=0x12345678; stallreq_o high for 9 cycles.
- LB addr 0x2003 byte 0x80 -> wdata_o=0xFFFFFF80. LBU on the same byte -> 0x00000080. LH on bytes 0xFF,0x7F -> 0x00007FFF.
- SH addr 0x3001 (misaligned), wdata=0xAABBCCDD -> writes DD@0x3001, CC@0x3002; wreg_o=0.
- DONE with wb_stall_i=1 for 3 cycles, rdy=0 for 2 cycles mid-BUSY -> no extra mc_req_o; state, address and outputs frozen; correct result delivered after release.
